// File: rtl/bootram_ctrl_pkg.sv
// Shared types and constants for the boot RAM controller.
// Holds the FSM state encoding, the grant encoding and the lane geometry.
// Contains no logic, so there is no latency or backpressure behaviour.
package bootram_ctrl_pkg;

    localparam int AW    = 11;
    localparam int LANES = 4;
    localparam int DEPTH = 2048;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    typedef enum logic {
        GNT_CPU = 1'b0,
        GNT_LDR = 1'b1
    } grant_t;

    // Chip-enable pattern that selects the single lane holding a byte address.
    function automatic logic [LANES-1:0] lane_onehot(input logic [1:0] sel);
        logic [LANES-1:0] oh;
        oh      = '0;
        oh[sel] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/bootram_rr_arb.sv
// Two-requester round-robin arbiter for the boot RAM controller.
// Latency: grant is combinational from the requests; last_grant updates at the grant edge.
// Backpressure: only sampled while the controller is idle; no grant is issued otherwise.
// Ports: clk/resetn, sample (controller idle), cpu_req/ldr_req, gnt_vld/gnt (winner).
module bootram_rr_arb
    import bootram_ctrl_pkg::*;
(
    input  logic   clk,
    input  logic   resetn,
    input  logic   sample,
    input  logic   cpu_req,
    input  logic   ldr_req,
    output logic   gnt_vld,
    output grant_t gnt
);

    grant_t last_grant;

    always_comb begin
        gnt_vld = sample && (cpu_req || ldr_req);
        gnt     = GNT_CPU;
        if (cpu_req && ldr_req) begin
            gnt = (last_grant == GNT_CPU) ? GNT_LDR : GNT_CPU;
        end else if (ldr_req) begin
            gnt = GNT_LDR;
        end
    end

    // Only a real conflict moves the round-robin pointer; an uncontested
    // grant leaves the priority order untouched.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_grant <= GNT_LDR;
        end else if (sample && cpu_req && ldr_req) begin
            last_grant <= gnt;
        end
    end

endmodule

// File: rtl/bootram_ctrl.sv
// Boot RAM controller: four 2Kx8 lanes presented as one 32-bit memory, shared by CPU and loader.
// Latency: from grant edge T, ram_ce in T+1; ready in T+2 (write) or T+3 (read).
// Backpressure: valid is held until the one-cycle ready; one transaction in flight, no grant until idle.
// Ports: cpu_* PicoRV32 native word port, ldr_* byte-write loader port, wprot blocks CPU writes,
//        ram_* shared lane interface (per-lane ce, common wre/ad, lane i on din/dout[8i+7:8i]).
module bootram_ctrl #(
    parameter int AW = 11
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          cpu_valid,
    output logic          cpu_ready,
    input  logic [12:0]   cpu_addr,
    input  logic [31:0]   cpu_wdata,
    input  logic [3:0]    cpu_wstrb,
    output logic [31:0]   cpu_rdata,
    input  logic          ldr_valid,
    output logic          ldr_ready,
    input  logic [12:0]   ldr_addr,
    input  logic [7:0]    ldr_wdata,
    input  logic          wprot,
    output logic [3:0]    ram_ce,
    output logic          ram_wre,
    output logic          ram_oce,
    output logic [AW-1:0] ram_ad,
    output logic [31:0]   ram_din,
    input  logic [31:0]   ram_dout
);
    import bootram_ctrl_pkg::*;

    state_t        state;
    state_t        state_nxt;
    logic          gnt_vld;
    grant_t        gnt;

    // Latched request: who owns the current transaction and whether it reads.
    grant_t        gnt_q;
    logic          rd_q;
    grant_t        gnt_q_nxt;
    logic          rd_q_nxt;

    logic [3:0]    ce_nxt;
    logic          wre_nxt;
    logic [AW-1:0] ad_nxt;
    logic [31:0]   din_nxt;
    logic          cpu_ready_nxt;
    logic          ldr_ready_nxt;
    logic [31:0]   rdata_nxt;

    // Byte-select bits of the CPU address are implied by cpu_wstrb.
    logic          unused_cpu_lsb;
    assign unused_cpu_lsb = ^cpu_addr[1:0];

    assign ram_oce = 1'b1;

    bootram_rr_arb u_arb (
        .clk     (clk),
        .resetn  (resetn),
        .sample  (state == IDLE),
        .cpu_req (cpu_valid),
        .ldr_req (ldr_valid),
        .gnt_vld (gnt_vld),
        .gnt     (gnt)
    );

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (gnt_vld) state_nxt = ACCESS;
            ACCESS:  state_nxt = rd_q ? WAIT : RESP;
            WAIT:    state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic. Every output is registered, so the lane controls are
    // computed at the grant edge and therefore appear during ACCESS.
    always_comb begin
        ce_nxt        = '0;
        wre_nxt       = 1'b0;
        ad_nxt        = ram_ad;
        din_nxt       = ram_din;
        cpu_ready_nxt = 1'b0;
        ldr_ready_nxt = 1'b0;
        rdata_nxt     = cpu_rdata;
        gnt_q_nxt     = gnt_q;
        rd_q_nxt      = rd_q;
        unique case (state)
            IDLE: begin
                if (gnt_vld) begin
                    gnt_q_nxt = gnt;
                    if (gnt == GNT_CPU) begin
                        ad_nxt   = cpu_addr[AW+1:2];
                        rd_q_nxt = (cpu_wstrb == 4'b0000);
                        if (cpu_wstrb == 4'b0000) begin
                            ce_nxt = '1;
                        end else if (!wprot) begin
                            ce_nxt  = cpu_wstrb;
                            wre_nxt = 1'b1;
                            din_nxt = cpu_wdata;
                        end
                        // Protected write: no lane enabled, still completes.
                    end else begin
                        ad_nxt   = ldr_addr[AW+1:2];
                        rd_q_nxt = 1'b0;
                        ce_nxt   = lane_onehot(ldr_addr[1:0]);
                        wre_nxt  = 1'b1;
                        din_nxt  = {LANES{ldr_wdata}};
                    end
                end
            end
            ACCESS: begin
                if (!rd_q) begin
                    cpu_ready_nxt = (gnt_q == GNT_CPU);
                    ldr_ready_nxt = (gnt_q == GNT_LDR);
                end
            end
            WAIT: begin
                // Lane output is valid one cycle after the CE edge.
                rdata_nxt     = ram_dout;
                cpu_ready_nxt = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ram_ce    <= '0;
            ram_wre   <= 1'b0;
            ram_ad    <= '0;
            ram_din   <= '0;
            cpu_ready <= 1'b0;
            ldr_ready <= 1'b0;
            cpu_rdata <= '0;
            gnt_q     <= GNT_CPU;
            rd_q      <= 1'b0;
        end else begin
            ram_ce    <= ce_nxt;
            ram_wre   <= wre_nxt;
            ram_ad    <= ad_nxt;
            ram_din   <= din_nxt;
            cpu_ready <= cpu_ready_nxt;
            ldr_ready <= ldr_ready_nxt;
            cpu_rdata <= rdata_nxt;
            gnt_q     <= gnt_q_nxt;
            rd_q      <= rd_q_nxt;
        end
    end

endmodule

// File: tb/tb_bootram_ctrl.sv
// Testbench for bootram_ctrl: directed steps plus randomized traffic against a word-level memory model.
// Latency: checks ready at T+2 (write) / T+3 (read) counted from the grant edge.
// Backpressure: requesters hold valid until ready, then drop it the following cycle.
module tb_bootram_ctrl;

    logic        clk;
    logic        resetn;
    logic        cpu_valid;
    logic        cpu_ready;
    logic [12:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_wstrb;
    logic [31:0] cpu_rdata;
    logic        ldr_valid;
    logic        ldr_ready;
    logic [12:0] ldr_addr;
    logic [7:0]  ldr_wdata;
    logic        wprot;
    logic [3:0]  ram_ce;
    logic        ram_wre;
    logic        ram_oce;
    logic [10:0] ram_ad;
    logic [31:0] ram_din;
    logic [31:0] ram_dout;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: one 32-bit word per word index, plus which words hold known data.
    logic [31:0] ref_mem [2048];
    bit          ref_known [2048];
    int          known_q [$];
    bit          last_conflict_cpu;  // winner of the most recent simultaneous request

    bootram_ctrl dut (
        .clk       (clk),
        .resetn    (resetn),
        .cpu_valid (cpu_valid),
        .cpu_ready (cpu_ready),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_wstrb (cpu_wstrb),
        .cpu_rdata (cpu_rdata),
        .ldr_valid (ldr_valid),
        .ldr_ready (ldr_ready),
        .ldr_addr  (ldr_addr),
        .ldr_wdata (ldr_wdata),
        .wprot     (wprot),
        .ram_ce    (ram_ce),
        .ram_wre   (ram_wre),
        .ram_oce   (ram_oce),
        .ram_ad    (ram_ad),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Four 2Kx8 lanes in bypass read mode.
    logic [7:0] lane_mem [4][2048];
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (ram_ce[i]) begin
                if (ram_wre) lane_mem[i][ram_ad] <= ram_din[8*i +: 8];
                else         ram_dout[8*i +: 8]  <= lane_mem[i][ram_ad];
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic void ref_write(input int idx, input logic [31:0] d, input logic [3:0] be);
        for (int b = 0; b < 4; b++) begin
            if (be[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
        end
        if (!ref_known[idx] && be == 4'hF) begin
            ref_known[idx] = 1'b1;
            known_q.push_back(idx);
        end
    endfunction

    task automatic cpu_op(input string tag, input logic [12:0] a, input logic [31:0] wd,
                          input logic [3:0] ws, input logic wp, output logic [31:0] rd);
        int k; bit got; bit stray; bit extra_ce;
        logic [3:0] exp_ce; logic exp_wre; int exp_lat;
        logic [3:0] ce_s; logic wre_s; logic [10:0] ad_s; logic [31:0] din_s;
        ce_s = '0; wre_s = 1'b0; ad_s = '0; din_s = '0;
        if (ws == 4'h0)  begin exp_ce = 4'hF; exp_wre = 1'b0; exp_lat = 3; end
        else if (wp)     begin exp_ce = 4'h0; exp_wre = 1'b0; exp_lat = 2; end
        else             begin exp_ce = ws;   exp_wre = 1'b1; exp_lat = 2; end
        @(posedge clk); #1;
        cpu_valid = 1'b1; cpu_addr = a; cpu_wdata = wd; cpu_wstrb = ws; wprot = wp;
        @(posedge clk);  // grant edge T
        k = 0; got = 0; stray = 0; extra_ce = 0;
        while (!got && k < 20) begin
            @(negedge clk); k++;
            if (k == 1) begin
                ce_s = ram_ce; wre_s = ram_wre; ad_s = ram_ad; din_s = ram_din;
            end else if (ram_ce != 4'h0) begin
                extra_ce = 1'b1;
            end
            if (ldr_ready) stray = 1'b1;
            if (cpu_ready) got = 1'b1;
        end
        rd = cpu_rdata;
        chk({tag, ".ce"}, 32'(ce_s), 32'(exp_ce));
        chk({tag, ".wre"}, 32'(wre_s), 32'(exp_wre));
        chk({tag, ".ad"}, 32'(ad_s), 32'(a[12:2]));
        if (exp_wre) chk({tag, ".din"}, din_s, wd);
        chk({tag, ".latency"}, 32'(k), 32'(exp_lat));
        chk({tag, ".ce_once"}, 32'(extra_ce), 32'd0);
        chk({tag, ".ldr_stray"}, 32'(stray), 32'd0);
        if (ws == 4'h0) chk({tag, ".rdata"}, rd, ref_mem[a[12:2]]);
        else if (!wp)   ref_write(int'(a[12:2]), wd, ws);
        @(posedge clk); #1;
        cpu_valid = 1'b0;
        @(negedge clk);
        chk({tag, ".ready_1cyc"}, 32'(cpu_ready), 32'd0);
    endtask

    task automatic ldr_op(input string tag, input logic [12:0] a, input logic [7:0] d, input logic wp);
        int k; bit got; bit stray;
        logic [3:0] ce_s; logic wre_s; logic [10:0] ad_s; logic [31:0] din_s;
        logic [3:0] exp_ce;
        ce_s = '0; wre_s = 1'b0; ad_s = '0; din_s = '0;
        exp_ce = 4'h1 << a[1:0];
        @(posedge clk); #1;
        ldr_valid = 1'b1; ldr_addr = a; ldr_wdata = d; wprot = wp;
        @(posedge clk);
        k = 0; got = 0; stray = 0;
        while (!got && k < 20) begin
            @(negedge clk); k++;
            if (k == 1) begin
                ce_s = ram_ce; wre_s = ram_wre; ad_s = ram_ad; din_s = ram_din;
            end
            if (cpu_ready) stray = 1'b1;
            if (ldr_ready) got = 1'b1;
        end
        chk({tag, ".ce"}, 32'(ce_s), 32'(exp_ce));
        chk({tag, ".wre"}, 32'(wre_s), 32'd1);
        chk({tag, ".ad"}, 32'(ad_s), 32'(a[12:2]));
        chk({tag, ".din"}, din_s, {d, d, d, d});
        chk({tag, ".latency"}, 32'(k), 32'd2);
        chk({tag, ".cpu_stray"}, 32'(stray), 32'd0);
        ref_write(int'(a[12:2]), {d, d, d, d}, exp_ce);
        @(posedge clk); #1;
        ldr_valid = 1'b0;
    endtask

    // CPU full-word write and loader byte write requested in the same cycle.
    task automatic conflict_pair(input string tag, input logic [12:0] ca, input logic [31:0] cd,
                                 input logic [12:0] la, input logic [7:0] ld);
        int k; bit cpu_done; bit ldr_done; bit first_cpu; bit both; int ce_cycles; bit exp_first_cpu;
        exp_first_cpu = !last_conflict_cpu;
        @(posedge clk); #1;
        cpu_valid = 1'b1; cpu_addr = ca; cpu_wdata = cd; cpu_wstrb = 4'hF; wprot = 1'b0;
        ldr_valid = 1'b1; ldr_addr = la; ldr_wdata = ld;
        @(posedge clk);
        k = 0; cpu_done = 0; ldr_done = 0; first_cpu = 0; both = 0; ce_cycles = 0;
        while ((!cpu_done || !ldr_done) && k < 30) begin
            @(negedge clk); k++;
            if (ram_ce != 4'h0) ce_cycles++;
            if (cpu_ready && ldr_ready) both = 1'b1;
            if (cpu_ready && !cpu_done && !ldr_done) first_cpu = 1'b1;
            if (cpu_ready) cpu_done = 1'b1;
            if (ldr_ready) ldr_done = 1'b1;
            @(posedge clk); #1;
            if (cpu_done) cpu_valid = 1'b0;
            if (ldr_done) ldr_valid = 1'b0;
        end
        cpu_valid = 1'b0; ldr_valid = 1'b0;
        chk({tag, ".cpu_first"}, 32'(first_cpu), 32'(exp_first_cpu));
        chk({tag, ".both_done"}, 32'(cpu_done && ldr_done), 32'd1);
        chk({tag, ".cycles"}, 32'(k), 32'd5);
        chk({tag, ".ce_cycles"}, 32'(ce_cycles), 32'd2);
        chk({tag, ".ready_overlap"}, 32'(both), 32'd0);
        last_conflict_cpu = exp_first_cpu;
        if (exp_first_cpu) begin
            ref_write(int'(ca[12:2]), cd, 4'hF);
            ref_write(int'(la[12:2]), {ld, ld, ld, ld}, 4'h1 << la[1:0]);
        end else begin
            ref_write(int'(la[12:2]), {ld, ld, ld, ld}, 4'h1 << la[1:0]);
            ref_write(int'(ca[12:2]), cd, 4'hF);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        resetn = 1'b0;
        cpu_valid = 1'b0; ldr_valid = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        last_conflict_cpu = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        bit ready_in_reset;
        resetn = 1'b0; cpu_valid = 1'b0; ldr_valid = 1'b0; wprot = 1'b0;
        cpu_addr = '0; cpu_wdata = '0; cpu_wstrb = '0; ldr_addr = '0; ldr_wdata = '0;
        last_conflict_cpu = 1'b0;
        for (int i = 0; i < 2048; i++) begin ref_mem[i] = '0; ref_known[i] = 1'b0; end

        // Reset values.
        repeat (3) @(negedge clk);
        chk("rst.ram_ce", 32'(ram_ce), 32'd0);
        chk("rst.ram_wre", 32'(ram_wre), 32'd0);
        chk("rst.ram_oce", 32'(ram_oce), 32'd1);
        chk("rst.ram_ad", 32'(ram_ad), 32'd0);
        chk("rst.ram_din", ram_din, 32'd0);
        chk("rst.cpu_ready", 32'(cpu_ready), 32'd0);
        chk("rst.ldr_ready", 32'(ldr_ready), 32'd0);
        chk("rst.cpu_rdata", cpu_rdata, 32'd0);
        resetn = 1'b1;

        // Full write, read back.
        cpu_op("t1.wr", 13'h0010, 32'hDEADBEEF, 4'hF, 1'b0, rd);
        cpu_op("t1.rd", 13'h0010, 32'h0, 4'h0, 1'b0, rd);
        chk("t1.const", rd, 32'hDEADBEEF);

        // Single-lane strobe.
        cpu_op("t2.wr", 13'h0010, 32'h00AA5500, 4'b0010, 1'b0, rd);
        cpu_op("t2.rd", 13'h0010, 32'h0, 4'h0, 1'b0, rd);
        chk("t2.const", rd, 32'hDEAD55EF);

        // Loader byte write into lane 3.
        ldr_op("t3.ldr", 13'h0013, 8'h7E, 1'b0);
        cpu_op("t3.rd", 13'h0010, 32'h0, 4'h0, 1'b0, rd);
        chk("t3.const", rd, 32'h7EAD55EF);

        // Round-robin on simultaneous requests, starting from reset.
        apply_reset();
        conflict_pair("t4.a", 13'h0100, 32'h01020304, 13'h0205, 8'hC3);
        conflict_pair("t4.b", 13'h0104, 32'hA5A5F00F, 13'h020A, 8'h3C);
        conflict_pair("t4.c", 13'h0108, 32'h13579BDF, 13'h020F, 8'h5A);
        cpu_op("t4.rd", 13'h0104, 32'h0, 4'h0, 1'b0, rd);
        chk("t4.const", rd, 32'hA5A5F00F);

        // Write protection drops CPU writes, never loader writes.
        cpu_op("t5.wp", 13'h0010, 32'h11223344, 4'hF, 1'b1, rd);
        cpu_op("t5.rd", 13'h0010, 32'h0, 4'h0, 1'b0, rd);
        chk("t5.const", rd, 32'h7EAD55EF);
        ldr_op("t5.ldr", 13'h0011, 8'h99, 1'b1);
        cpu_op("t5.rd2", 13'h0010, 32'h0, 4'h0, 1'b1, rd);
        chk("t5.const2", rd, 32'h7EAD99EF);

        // Reset during the WAIT cycle of a read.
        @(posedge clk); #1;
        cpu_valid = 1'b1; cpu_addr = 13'h0010; cpu_wstrb = 4'h0; wprot = 1'b0;
        @(posedge clk);
        @(negedge clk);  // ACCESS
        @(negedge clk);  // WAIT
        resetn = 1'b0;
        #1;
        chk("t6.ram_ce", 32'(ram_ce), 32'd0);
        chk("t6.cpu_ready", 32'(cpu_ready), 32'd0);
        chk("t6.cpu_rdata", cpu_rdata, 32'd0);
        chk("t6.ram_ad", 32'(ram_ad), 32'd0);
        chk("t6.ram_oce", 32'(ram_oce), 32'd1);
        cpu_valid = 1'b0;
        ready_in_reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (cpu_ready || ldr_ready) ready_in_reset = 1'b1;
        end
        chk("t6.no_ready", 32'(ready_in_reset), 32'd0);
        resetn = 1'b1;
        last_conflict_cpu = 1'b0;
        cpu_op("t6.rd", 13'h0010, 32'h0, 4'h0, 1'b0, rd);
        chk("t6.const", rd, 32'h7EAD99EF);

        // Randomized traffic against the word model.
        for (int n = 0; n < 60; n++) begin
            int kind;
            logic [12:0] a;
            kind = $urandom_range(0, 3);
            a = ($urandom_range(0, 1) == 0) ? 13'($urandom_range(0, 63)) : 13'($urandom_range(0, 8191));
            case (kind)
                0: cpu_op("rnd.wr", a, $urandom, 4'($urandom_range(1, 15)),
                          1'($urandom_range(0, 3) == 0), rd);
                1: ldr_op("rnd.ldr", a, 8'($urandom), 1'($urandom_range(0, 1)));
                default: begin
                    int idx;
                    idx = known_q[$urandom_range(0, known_q.size() - 1)];
                    cpu_op("rnd.rd", 13'(idx << 2) | 13'($urandom_range(0, 3)), 32'h0, 4'h0,
                           1'($urandom_range(0, 1)), rd);
                end
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
